wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Round-robin arbiter that shares one pipelined Wishbone slave, such as the PWM peripheral, between `MASTERS` requesters: board-level sequencers, a UART command bridge, and similar. It accepts one request at a time from the winning master and latches it. It drives the slave through request and acknowledge, then returns the acknowledge and read data to the owner. A watchdog converts a missing acknowledge into an error pulse so the bus cannot hang.

## Interface
- `MASTERS`, default 2: number of requesters, 2..8.
- `ADDR_BITS`, default 32: address width.
- `DATA_BITS`, default 32: data width.
- `TIMEOUT`, default 255: maximum cycles from slave strobe to slave ack before abort; must be ≥2.

Ports (name, direction, width, meaning):
- `i_wb_clk` in 1: single clock.
- `i_wb_rst` in 1: reset, synchronous, active-high.
- `i_m_stb` in MASTERS: request strobe per master.
- `i_m_we` in MASTERS: write enable per master.
- `i_m_addr` in MASTERS*ADDR_BITS: flattened addresses; master k occupies bits [k*ADDR_BITS +: ADDR_BITS].
- `i_m_data` in MASTERS*DATA_BITS: flattened write data, same packing.
- `o_m_stall` out MASTERS: per-master stall; low means the request is taken this cycle.
- `o_m_ack` out MASTERS: per-master one-cycle completion pulse.
- `o_m_err` out MASTERS: per-master one-cycle timeout pulse.
- `o_m_data` out DATA_BITS: read data, shared, valid with `o_m_ack`.
- `o_s_stb` out 1: slave strobe.
- `o_s_we` out 1: slave write enable.
- `o_s_addr` out ADDR_BITS: slave address.
- `o_s_data` out DATA_BITS: slave write data.
- `i_s_stall` in 1: slave stall.
- `i_s_ack` in 1: slave acknowledge.
- `i_s_data` in DATA_BITS: slave read data.

## Operation
- States:
  - IDLE=0
  - REQUEST=1
  - WAIT_ACK=2
  - RESPOND=3
- IDLE, picking the winner:
  - Winner = first master with `i_m_stb` high, searching from `prio` upward and wrapping mod MASTERS.
  - `o_m_stall[winner]`=0 combinationally; every other stall bit is 1.
  - On that edge: latch we/addr/data and `owner`=winner, clear the watchdog, go to REQUEST.
- Outside IDLE, all `o_m_stall` bits are 1.
- REQUEST:
  - `o_s_stb`=1, slave outputs driven from the latch.
  - `i_s_stall`=0 and `i_s_ack`=1 → latch `i_s_data`, go to RESPOND.
  - `i_s_stall`=0 and `i_s_ack`=0 → go to WAIT_ACK.
  - `i_s_stall`=1 → stay.
- WAIT_ACK: `o_s_stb`=0; `i_s_ack`=1 → latch `i_s_data`, go to RESPOND.
- RESPOND: `o_m_ack[owner]`=1 for one cycle, `o_m_data`=latched data, `prio`=(owner+1) mod MASTERS, go to IDLE.
- Watchdog:
  - 8-bit-or-wider counter, increments every cycle in REQUEST/WAIT_ACK.
  - Reaching TIMEOUT-1 without ack → `o_m_err[owner]` pulses one cycle (registered), `prio` advances, go to IDLE.
- Ack and timeout in the same cycle: ack wins.
- Acks arriving in IDLE or RESPOND are ignored.
- `o_s_we`/`o_s_addr`/`o_s_data` hold the last latched values outside REQUEST; only `o_s_stb` qualifies them.

## Timing
- Reset values:
  - state=IDLE, `prio`=0, `owner`=0, latches 0.
  - `o_s_stb`=0, `o_m_ack`=0, `o_m_err`=0, `o_m_data`=0.
  - `o_m_stall`: combinational per the IDLE rule.
- Reset mid-transaction discards it; no ack or err is issued; the slave sees `o_s_stb` fall the next cycle.
- Latency:
  - Master accepted at cycle 0; `o_s_stb` high at cycle 1.
  - Zero-stall slave acking at cycle 2 → `o_m_ack` at cycle 3.
  - Minimum request-to-ack latency is 3 cycles; throughput is one transaction per 4 cycles.
- Each stall cycle and each ack-wait cycle adds one cycle.
- Fairness: a master requesting continuously waits at most MASTERS-1 transactions.

## Structure
- Shared package (`wb_pkg`): state encodings, `wb_arbiter` flattening index helpers.
- One sub-module `rr_pick`: combinational round-robin priority encoder.
  - Inputs: `req[MASTERS]`, `prio`.
  - Outputs: `valid`, `idx`.
- All sequencing stays in `wb_arbiter`.

## Test plan
- Single master 0, write addr=1 data=3'b011, slave zero-stall with ack next cycle → `o_s_stb` at cycle 1, `o_m_ack[0]` at cycle 3, no `o_m_ack[1]`.
- Both masters strobing continuously from reset → grants alternate 0,1,0,1; each ack goes to the correct index.
- Slave stalls 3 cycles then acks in the same cycle as accept → `o_s_stb` high 4 cycles, `o_m_ack` 1 cycle later; read data 0xA5 appears on `o_m_data`.
- Slave never acks, TIMEOUT=8 → `o_m_err[owner]` pulses once, no ack; the next master is served afterwards.
- `i_wb_rst` asserted in WAIT_ACK → outputs return to reset values, no ack or err; after release, master 0 has priority.
- Spurious `i_s_ack` in IDLE → no `o_m_ack` pulse, state unchanged.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone round-robin arbiter.
// State encodings, watchdog sizing and flattened-bus index helpers.
// Pure declarations; no logic, no latency, no flow control.
package wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQUEST  = 2'd1,
    ST_WAIT_ACK = 2'd2,
    ST_RESPOND  = 2'd3
  } wb_state_t;

  // The watchdog is never narrower than a byte so small TIMEOUTs stay cheap to retune.
  localparam int WD_MIN_BITS = 8;

  // Low bit of master k's field inside a flattened per-master bus.
  function automatic int flat_lo(input int k, input int width);
    return k * width;
  endfunction

  // Counter width able to hold TIMEOUT.
  function automatic int wd_bits(input int timeout);
    int b;
    b = $clog2(timeout + 1);
    return (b < WD_MIN_BITS) ? WD_MIN_BITS : b;
  endfunction

  // Round-robin successor of idx among n requesters.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/wb_arbiter_rr_pick.sv
// Round-robin priority encoder: first set request at or after prio, wrapping.
// Latency: purely combinational, zero cycles.
// Backpressure: none; valid is low when no request bit is set.
module rr_pick #(
  parameter int MASTERS = 2,
  parameter int IDX_W   = $clog2(MASTERS)
) (
  input  logic [MASTERS-1:0] req,
  input  logic [IDX_W-1:0]   prio,
  output logic               valid,
  output logic [IDX_W-1:0]   idx
);

  logic [2*MASTERS-1:0] w_dbl;
  logic [MASTERS-1:0]   w_rot;
  logic [IDX_W:0]       w_sum;

  // Doubling the vector turns the wrap-around search into a plain shift.
  assign w_dbl = {req, req};
  assign w_rot = MASTERS'(w_dbl >> prio);

  // Lowest set bit of the rotated vector is the nearest requester; map it back to an index.
  always_comb begin
    valid = 1'b0;
    w_sum = '0;
    for (int i = MASTERS - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        valid = 1'b1;
        w_sum = {1'b0, prio} + (IDX_W+1)'(i);
      end
    end
    if (w_sum >= (IDX_W+1)'(MASTERS)) begin
      w_sum = w_sum - (IDX_W+1)'(MASTERS);
    end
    idx = w_sum[IDX_W-1:0];
  end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin arbiter sharing one pipelined Wishbone slave among MASTERS requesters.
// Latency: accept at cycle 0, slave strobe at 1, master ack at 3 minimum (ack arrives at 2).
// Backpressure: one transaction in flight; all masters stalled outside IDLE, watchdog aborts a silent slave.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int MASTERS   = 2,
  parameter int ADDR_BITS = 32,
  parameter int DATA_BITS = 32,
  parameter int TIMEOUT   = 255
) (
  input  logic                         i_wb_clk,
  input  logic                         i_wb_rst,
  input  logic [MASTERS-1:0]           i_m_stb,
  input  logic [MASTERS-1:0]           i_m_we,
  input  logic [MASTERS*ADDR_BITS-1:0] i_m_addr,
  input  logic [MASTERS*DATA_BITS-1:0] i_m_data,
  output logic [MASTERS-1:0]           o_m_stall,
  output logic [MASTERS-1:0]           o_m_ack,
  output logic [MASTERS-1:0]           o_m_err,
  output logic [DATA_BITS-1:0]         o_m_data,
  output logic                         o_s_stb,
  output logic                         o_s_we,
  output logic [ADDR_BITS-1:0]         o_s_addr,
  output logic [DATA_BITS-1:0]         o_s_data,
  input  logic                         i_s_stall,
  input  logic                         i_s_ack,
  input  logic [DATA_BITS-1:0]         i_s_data
);

  localparam int              IDX_W   = $clog2(MASTERS);
  localparam int              WD_W    = wd_bits(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  wb_state_t            r_state;
  logic [IDX_W-1:0]     r_prio;
  logic [IDX_W-1:0]     r_owner;
  logic                 r_we;
  logic [ADDR_BITS-1:0] r_addr;
  logic [DATA_BITS-1:0] r_wdata;
  logic [DATA_BITS-1:0] r_rdata;
  logic                 r_stb;
  logic [MASTERS-1:0]   r_ack;
  logic [MASTERS-1:0]   r_err;
  logic [WD_W-1:0]      r_wdog;

  logic                 w_valid;
  logic [IDX_W-1:0]     w_idx;
  logic [IDX_W-1:0]     w_next_prio;
  logic                 w_sel_we;
  logic [ADDR_BITS-1:0] w_sel_addr;
  logic [DATA_BITS-1:0] w_sel_data;
  logic [MASTERS-1:0]   w_stall;
  logic [MASTERS-1:0]   w_owner_oh;
  logic                 w_take_ack;
  logic                 w_expire;
  logic [ADDR_BITS-1:0] w_addr_arr [MASTERS];
  logic [DATA_BITS-1:0] w_data_arr [MASTERS];

  rr_pick #(
    .MASTERS (MASTERS),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req   (i_m_stb),
    .prio  (r_prio),
    .valid (w_valid),
    .idx   (w_idx)
  );

  for (genvar g = 0; g < MASTERS; g++) begin : g_split
    assign w_addr_arr[g] = i_m_addr[flat_lo(g, ADDR_BITS) +: ADDR_BITS];
    assign w_data_arr[g] = i_m_data[flat_lo(g, DATA_BITS) +: DATA_BITS];
  end

  // Steer the winner's request fields and decode the grant and owner one-hots.
  always_comb begin
    w_sel_we   = 1'b0;
    w_sel_addr = '0;
    w_sel_data = '0;
    w_stall    = '1;
    w_owner_oh = '0;
    for (int k = 0; k < MASTERS; k++) begin
      if (w_idx == IDX_W'(k)) begin
        w_sel_we   = i_m_we[k];
        w_sel_addr = w_addr_arr[k];
        w_sel_data = w_data_arr[k];
        if (r_state == ST_IDLE && w_valid) begin
          w_stall[k] = 1'b0;
        end
      end
      if (r_owner == IDX_W'(k)) begin
        w_owner_oh[k] = 1'b1;
      end
    end
  end

  // An ack counts only once the strobe has been accepted (or in the same accepting cycle).
  assign w_take_ack  = i_s_ack && ((r_state == ST_REQUEST && !i_s_stall) || r_state == ST_WAIT_ACK);
  assign w_expire    = (r_wdog == WD_LAST);
  assign w_next_prio = IDX_W'(rr_next(int'(r_owner), MASTERS));

  // Transaction sequencer: grant, drive the slave, collect the ack or abort on the watchdog.
  always_ff @(posedge i_wb_clk) begin
    if (i_wb_rst) begin
      r_state <= ST_IDLE;
      r_prio  <= '0;
      r_owner <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_stb   <= 1'b0;
      r_ack   <= '0;
      r_err   <= '0;
      r_wdog  <= '0;
    end else begin
      r_ack <= '0;
      r_err <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_valid) begin
            r_we    <= w_sel_we;
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_data;
            r_owner <= w_idx;
            r_wdog  <= '0;
            r_stb   <= 1'b1;
            r_state <= ST_REQUEST;
          end
        end
        ST_REQUEST, ST_WAIT_ACK: begin
          r_wdog <= r_wdog + WD_W'(1);
          if (w_take_ack) begin
            r_rdata <= i_s_data;
            r_ack   <= w_owner_oh;
            r_stb   <= 1'b0;
            r_state <= ST_RESPOND;
          end else if (w_expire) begin
            r_err   <= w_owner_oh;
            r_prio  <= w_next_prio;
            r_stb   <= 1'b0;
            r_state <= ST_IDLE;
          end else if (r_state == ST_REQUEST && !i_s_stall) begin
            r_stb   <= 1'b0;
            r_state <= ST_WAIT_ACK;
          end
        end
        ST_RESPOND: begin
          r_prio  <= w_next_prio;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_m_stall = w_stall;
  assign o_m_ack   = r_ack;
  assign o_m_err   = r_err;
  assign o_m_data  = r_rdata;
  assign o_s_stb   = r_stb;
  assign o_s_we    = r_we;
  assign o_s_addr  = r_addr;
  assign o_s_data  = r_wdata;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: transaction-level reference model checked every cycle,
// plus directed scenarios with hand-computed cycle numbers and data.
module tb_wb_arbiter;
  localparam int M  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [M-1:0]    m_stb = '0;
  logic [M-1:0]    m_we = '0;
  logic [M*AW-1:0] m_addr = '0;
  logic [M*DW-1:0] m_data = '0;
  logic [M-1:0]    m_stall, m_ack, m_err;
  logic [DW-1:0]   m_rdata;
  logic            s_stb, s_we;
  logic [AW-1:0]   s_addr;
  logic [DW-1:0]   s_wdata;
  logic            s_stall = 1'b0;
  logic            s_ack = 1'b0;
  logic [DW-1:0]   s_rdata = '0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  wb_arbiter #(.MASTERS(M), .ADDR_BITS(AW), .DATA_BITS(DW), .TIMEOUT(TO)) dut (
    .i_wb_clk(clk), .i_wb_rst(rst),
    .i_m_stb(m_stb), .i_m_we(m_we), .i_m_addr(m_addr), .i_m_data(m_data),
    .o_m_stall(m_stall), .o_m_ack(m_ack), .o_m_err(m_err), .o_m_data(m_rdata),
    .o_s_stb(s_stb), .o_s_we(s_we), .o_s_addr(s_addr), .o_s_data(s_wdata),
    .i_s_stall(s_stall), .i_s_ack(s_ack), .i_s_data(s_rdata)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  int cyc = 0;
  bit mdl_ok = 0;
  bit mb, mresp, mhs;
  int mown, mprio, macc;
  logic [M-1:0]  e_ack, e_err;
  logic          e_stb, e_we;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata, e_rdata;

  function automatic int pick(input logic [M-1:0] req, input int from);
    for (int i = 0; i < M; i++) if (req[(from + i) % M]) return (from + i) % M;
    return -1;
  endfunction

  always @(posedge clk) begin : mdl
    int w;
    bit took;
    if (rst) begin
      mb = 0; mresp = 0; mhs = 0; mown = 0; mprio = 0; macc = 0;
      e_ack = '0; e_err = '0; e_stb = 0; e_we = 0; e_addr = '0; e_wdata = '0; e_rdata = '0;
      mdl_ok = 1;
    end else begin
      e_ack = '0;
      e_err = '0;
      if (mresp) begin
        mresp = 0; mb = 0; mprio = (mown + 1) % M;
      end else if (!mb) begin
        w = pick(m_stb, mprio);
        if (w >= 0) begin
          mb = 1; mown = w; macc = cyc; mhs = 0; e_stb = 1;
          e_we = m_we[w]; e_addr = m_addr[w*AW +: AW]; e_wdata = m_data[w*DW +: DW];
        end
      end else begin
        took = s_ack && (mhs || !s_stall);
        if (took) begin
          e_rdata = s_rdata; e_ack[mown] = 1'b1; mresp = 1; e_stb = 0;
        end else if (cyc - macc == TO) begin
          e_err[mown] = 1'b1; mb = 0; mprio = (mown + 1) % M; e_stb = 0;
        end else if (!mhs && !s_stall) begin
          mhs = 1; e_stb = 0;
        end
      end
    end
    cyc++;
  end

  always @(negedge clk) begin : cmp
    logic [M-1:0] es;
    int w;
    if (mdl_ok) begin
      es = '1;
      if (!mb) begin
        w = pick(m_stb, mprio);
        if (w >= 0) es[w] = 1'b0;
      end
      chk("m_stall", m_stall, es);
      chk("m_ack", m_ack, e_ack);
      chk("m_err", m_err, e_err);
      chk("s_stb", s_stb, e_stb);
      chk("s_we", s_we, e_we);
      chk("s_addr", s_addr, e_addr);
      chk("s_data", s_wdata, e_wdata);
      chk("m_data", m_rdata, e_rdata);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1; m_stb = '0; s_ack = 0; s_stall = 0;
    step(); step();
    rst = 0;
  endtask

  // One transaction from master k; slave stalls nstall cycles, then acks either
  // in its accepting cycle (ack_w_acc) or the cycle after.
  task automatic run_txn(input int k, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input int nstall, input bit ack_w_acc, input logic [DW-1:0] rdata,
                         output int t_stb, output int lat, output int nstb,
                         output logic [M-1:0] ackv, output logic [DW-1:0] rd);
    int t, tacc;
    bit done;
    tacc = -1; done = 0; nstb = 0; lat = -1; t_stb = -1; ackv = '0; rd = '0;
    m_stb[k] = 1'b1; m_we[k] = we; m_addr[k*AW +: AW] = a; m_data[k*DW +: DW] = d;
    s_stall = 0; s_ack = 0; s_rdata = rdata;
    for (t = 0; t < 40 && !done; t++) begin
      look();
      if (tacc < 0 && m_stb[k] && !m_stall[k]) tacc = t;
      if (s_stb) begin
        nstb++;
        if (t_stb < 0) t_stb = t - tacc;
      end
      if (m_ack != '0) begin
        lat = t - tacc; ackv = m_ack; rd = m_rdata; done = 1;
      end
      step();
      if (tacc >= 0) begin : drv
        int n;
        n = t + 1 - tacc;
        m_stb[k] = 1'b0;
        s_stall = (n <= nstall);
        s_ack = ack_w_acc ? (n == nstall + 1) : (n == nstall + 2);
      end
    end
    s_ack = 0; s_stall = 0;
    chk("txn_done", {63'd0, done}, 64'd1);
  endtask

  initial begin
    int t_stb, lat, nstb, sampled;
    logic [M-1:0] ackv, errv;
    logic [DW-1:0] rd;
    int gq[$];
    int aq[$];
    int err_t, nerr, g1_t, ack1_t, nack0;

    // reset values
    rst = 1;
    step(); step(); step();
    look();
    chk("rst_s_stb", s_stb, 0);
    chk("rst_m_ack", m_ack, 0);
    chk("rst_m_err", m_err, 0);
    chk("rst_m_data", m_rdata, 0);
    chk("rst_m_stall", m_stall, 2'b11);
    step();
    rst = 0;

    // T1: master 0 write, zero-stall slave acking the cycle after strobe
    run_txn(0, 1'b1, 32'h1, 32'h3, 0, 1'b0, 32'h0, t_stb, lat, nstb, ackv, rd);
    chk("t1_stb_cycle", t_stb, 1);
    chk("t1_ack_cycle", lat, 3);
    chk("t1_nstb", nstb, 1);
    chk("t1_ack_vec", ackv, 2'b01);

    // T2: both strobing from reset, grants and acks alternate 0,1,0,1
    do_reset();
    m_stb = 2'b11; m_we = 2'b00;
    m_addr = {32'h200, 32'h100};
    s_stall = 0; s_ack = 0;
    for (int t = 0; t < 18; t++) begin
      look();
      for (int i = 0; i < M; i++) begin
        if (!m_stall[i]) gq.push_back(i);
        if (m_ack[i]) aq.push_back(i);
      end
      sampled = int'(s_stb);
      step();
      s_ack = (sampled != 0);
      s_rdata = 32'h1000 + t;
    end
    m_stb = '0; s_ack = 0;
    chk("t2_ngrant", {63'd0, gq.size() >= 4}, 64'd1);
    chk("t2_nack", {63'd0, aq.size() >= 4}, 64'd1);
    for (int i = 0; i < 4; i++) begin
      if (i < gq.size()) chk("t2_grant_idx", gq[i], i % 2);
      if (i < aq.size()) chk("t2_ack_idx", aq[i], i % 2);
    end

    // T3: master 1 read, slave stalls 3 cycles then acks while accepting, data A5
    do_reset();
    run_txn(1, 1'b0, 32'h40, 32'h0, 3, 1'b1, 32'hA5, t_stb, lat, nstb, ackv, rd);
    chk("t3_nstb", nstb, 4);
    chk("t3_ack_cycle", lat, 5);
    chk("t3_ack_vec", ackv, 2'b10);
    chk("t3_rdata", rd, 32'hA5);

    // T4: slave never acks master 0 -> single err at cycle 9, master 1 then served
    do_reset();
    m_stb = 2'b01; m_addr = {32'h44, 32'h33};
    s_stall = 0; s_ack = 0;
    err_t = -1; nerr = 0; g1_t = -1; ack1_t = -1; nack0 = 0; errv = '0;
    for (int t = 0; t < 16; t++) begin
      look();
      if (m_err != '0) begin nerr++; errv = m_err; err_t = t; end
      if (m_ack[0]) nack0++;
      if (m_ack[1] && ack1_t < 0) ack1_t = t;
      if (m_stb[1] && !m_stall[1] && g1_t < 0) g1_t = t;
      step();
      m_stb[0] = 1'b0;
      m_stb[1] = (g1_t < 0);
      s_ack = (g1_t >= 0 && t + 1 == g1_t + 2);
    end
    m_stb = '0; s_ack = 0;
    chk("t4_nerr", nerr, 1);
    chk("t4_err_cycle", err_t, 9);
    chk("t4_err_vec", errv, 2'b01);
    chk("t4_no_ack0", nack0, 0);
    chk("t4_grant1_cycle", g1_t, 9);
    chk("t4_ack1_cycle", ack1_t, 12);

    // T5: reset while master 1 waits for ack
    do_reset();
    run_txn(0, 1'b1, 32'h10, 32'h20, 0, 1'b0, 32'h77, t_stb, lat, nstb, ackv, rd);
    chk("t5_pre_rdata", rd, 32'h77);
    m_stb = 2'b10; m_addr[AW +: AW] = 32'h88;
    look();
    chk("t5_grant1", m_stall, 2'b01);
    step();
    m_stb = '0;
    look();
    chk("t5_req_stb", s_stb, 1);
    step();
    rst = 1; s_ack = 1; s_rdata = 32'hBAD;
    look();
    chk("t5_wait_stb", s_stb, 0);
    step();
    look();
    chk("t5_rst_stb", s_stb, 0);
    chk("t5_rst_ack", m_ack, 0);
    chk("t5_rst_err", m_err, 0);
    chk("t5_rst_data", m_rdata, 0);
    chk("t5_rst_addr", s_addr, 0);
    step();
    rst = 0; s_ack = 0; m_stb = 2'b11;
    m_addr = {32'h99, 32'h66};
    look();
    chk("t5_prio0", m_stall, 2'b10);
    step();
    m_stb = '0; s_ack = 1; s_rdata = 32'h55;
    look();
    chk("t5_req_addr", s_addr, 32'h66);
    step();
    s_ack = 0;
    look();
    chk("t5_ack_vec", m_ack, 2'b01);
    chk("t5_ack_data", m_rdata, 32'h55);
    step();

    // T6: spurious acks in IDLE are ignored
    s_ack = 1; s_rdata = 32'hDEAD;
    for (int t = 0; t < 3; t++) begin
      look();
      chk("t6_no_ack", m_ack, 0);
      step();
    end
    s_ack = 0;
    look();
    chk("t6_data_held", m_rdata, 32'h55);
    step();
    run_txn(1, 1'b1, 32'h5, 32'h6, 0, 1'b0, 32'h0, t_stb, lat, nstb, ackv, rd);
    chk("t6_after_lat", lat, 3);
    chk("t6_after_vec", ackv, 2'b10);

    repeat (3) step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
